// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the BCD limit counter datapath.
//   DIGITS_DEFAULT  default number of BCD digits
//   BCD_MAX_DIGITS  widest counter the helper functions support
//   BCD_NINE        largest legal BCD digit value
//   bcd_word_t      BCD word for the default digit count
//   digit_op_t      per-cycle operation broadcast to every digit slice
//   all_nines()     all-nines wrap point for a given digit count
//   clamp_digit()   saturates a nibble to a legal BCD digit
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int DIGITS_DEFAULT = 6;
  localparam int BCD_MAX_DIGITS = 16;
  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef logic [4*DIGITS_DEFAULT-1:0] bcd_word_t;

  // One operation is chosen per cycle at the top level and applied by all
  // digits; INC/DEC are further gated per digit by the ripple chain.
  typedef enum logic [2:0] {
    DOP_HOLD = 3'd0,
    DOP_ZERO = 3'd1,
    DOP_LOAD = 3'd2,
    DOP_INC  = 3'd3,
    DOP_DEC  = 3'd4
  } digit_op_t;

  // Builds 0x99..9 in the low 'digits' nibbles, zero above.
  function automatic logic [4*BCD_MAX_DIGITS-1:0] all_nines(input int unsigned digits);
    logic [4*BCD_MAX_DIGITS-1:0] word;
    word = '0;
    for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < digits) begin
        word[4*i +: 4] = BCD_NINE;
      end else begin
        word[4*i +: 4] = 4'd0;
      end
    end
    return word;
  endfunction

  // A limit nibble above 9 is loaded as 9 so the count stays pure BCD.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    logic [3:0] r;
    if (d > BCD_NINE) begin
      r = BCD_NINE;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One BCD digit slice of the limit counter ripple chain.
// Build option: BCD_COUNTER_DOWN_EN enables the decrement path.
// Ports:
//   clk       system clock
//   reset     synchronous active-high clear
//   op        operation for this cycle (hold / zero / load / inc / dec)
//   load_val  nibble loaded on DOP_LOAD (clamped to 9)
//   cin       ripple carry-in; the digit increments only when set
//   bin       ripple borrow-in; the digit decrements only when set
//   q         current digit value (registered)
//   cout      carry to next digit (cin and digit at 9)
//   bout      borrow to next digit (bin and digit at 0)
// -----------------------------------------------------------------------------
module bcd_digit
  import counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  digit_op_t  op,
  input  logic [3:0] load_val,
  input  logic       cin,
  input  logic       bin,
  output logic [3:0] q,
  output logic       cout,
  output logic       bout
);

  logic [3:0] q_r;

  assign q    = q_r;
  assign cout = cin & (q_r >= BCD_NINE);
  assign bout = bin & (q_r == 4'd0);

  // Digit register: reset, then the broadcast operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= 4'd0;
    end else begin
      case (op)
        DOP_ZERO: q_r <= 4'd0;
        DOP_LOAD: q_r <= clamp_digit(load_val);
        DOP_INC: begin
          if (cin) begin
            q_r <= (q_r >= BCD_NINE) ? 4'd0 : q_r + 4'd1;
          end else begin
            q_r <= q_r;
          end
        end
`ifdef BCD_COUNTER_DOWN_EN
        DOP_DEC: begin
          if (bin) begin
            q_r <= (q_r == 4'd0) ? BCD_NINE : q_r - 4'd1;
          end else begin
            q_r <= q_r;
          end
        end
`endif
        default: q_r <= q_r;
      endcase
    end
  end

endmodule

// File: rtl/bcd_limit_counter.sv
// -----------------------------------------------------------------------------
// bcd_limit_counter
// Multi-digit BCD event counter with a configurable wrap point.
// Build option: BCD_COUNTER_DOWN_EN enables down counting via up_down;
// without it the counter counts up only and up_down is ignored.
// Ports:
//   clk        system clock
//   reset      synchronous active-high; clears count and carry
//   step       single-cycle count request
//   up_down    1 = up, 0 = down (only with BCD_COUNTER_DOWN_EN)
//   clear      synchronous clear of the count (beats step)
//   max_in     BCD limit from mode-select
//   max_en     limit active; otherwise the wrap point is all nines
//   carry_en   enables the carry/borrow pulse
//   cnt_out    current BCD count
//   carry_out  registered one-cycle pulse after a wrapping step
//   at_limit   count equals the wrap point (up) or zero (down)
// -----------------------------------------------------------------------------
module bcd_limit_counter
  import counter_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step,
  input  logic                up_down,
  input  logic                clear,
  input  logic [4*DIGITS-1:0] max_in,
  input  logic                max_en,
  input  logic                carry_en,
  output logic [4*DIGITS-1:0] cnt_out,
  output logic                carry_out,
  output logic                at_limit
);

  localparam int W = 4*DIGITS;
  localparam logic [4*BCD_MAX_DIGITS-1:0] NINES_FULL = all_nines(DIGITS);
  localparam logic [W-1:0] NINES = NINES_FULL[W-1:0];

  logic [W-1:0]    cnt_s;
  logic [W-1:0]    top_s;
  logic            ge_top_s;
  logic            up_s;
  logic            wrap_s;
  digit_op_t       op_s;
  logic [DIGITS:0] cchain_s;
  logic [DIGITS:0] bchain_s;
  logic            carry_r;
  logic            unused_s;

  assign top_s    = max_en ? max_in : NINES;
  // Unsigned compare also catches a limit lowered below the live count.
  assign ge_top_s = (cnt_s >= top_s);

`ifdef BCD_COUNTER_DOWN_EN
  logic zero_s;
  assign zero_s   = (cnt_s == '0);
  assign up_s     = up_down;
  assign unused_s = ^{cchain_s[DIGITS], bchain_s[DIGITS]};
`else
  assign up_s     = 1'b1;
  assign unused_s = ^{cchain_s[DIGITS], bchain_s[DIGITS], up_down};
`endif

  // Priority decode: clear beats step; selects the digit operation and wrap.
  always_comb begin
    op_s   = DOP_HOLD;
    wrap_s = 1'b0;
    if (clear) begin
      op_s = DOP_ZERO;
    end else if (step) begin
      if (up_s) begin
        if (ge_top_s) begin
          op_s   = DOP_ZERO;
          wrap_s = 1'b1;
        end else begin
          op_s = DOP_INC;
        end
      end else begin
`ifdef BCD_COUNTER_DOWN_EN
        if (zero_s) begin
          op_s   = DOP_LOAD;
          wrap_s = 1'b1;
        end else if (max_en && (cnt_s > top_s)) begin
          // Limit dropped below the count: snap to it without a borrow.
          op_s = DOP_LOAD;
        end else begin
          op_s = DOP_DEC;
        end
`else
        op_s = DOP_HOLD;
`endif
      end
    end else begin
      op_s = DOP_HOLD;
    end
  end

  assign cchain_s[0] = 1'b1;
  assign bchain_s[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk      (clk),
        .reset    (reset),
        .op       (op_s),
        .load_val (top_s[4*gi +: 4]),
        .cin      (cchain_s[gi]),
        .bin      (bchain_s[gi]),
        .q        (cnt_s[4*gi +: 4]),
        .cout     (cchain_s[gi+1]),
        .bout     (bchain_s[gi+1])
      );
    end
  endgenerate

  // Carry/borrow pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_r <= 1'b0;
    end else begin
      carry_r <= wrap_s & carry_en;
    end
  end

  // Limit flag follows the active direction.
  always_comb begin
    at_limit = 1'b0;
`ifdef BCD_COUNTER_DOWN_EN
    if (up_s) begin
      at_limit = (cnt_s == top_s);
    end else begin
      at_limit = zero_s;
    end
`else
    at_limit = (cnt_s == top_s);
`endif
  end

  assign cnt_out   = cnt_s;
  assign carry_out = carry_r;

endmodule
